// File: rtl/sram_bus_slave.sv
// sram_bus_slave: 32-bit waitrequest bus to 16-bit async SRAM, one SETUP/STROBE/HOLD cycle set per halfword.
// SRAM_FAST_READ_EN: when defined, reads skip HOLD and go straight to the next half or DONE.
module sram_bus_slave #(
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic [31:0]        address,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        writedata,
    input  logic [3:0]         byteenable,
    output logic [31:0]        readdata,
    output logic               waitrequest,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_in,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_lb_n,
    output logic               sram_ub_n
);
`ifdef SRAM_FAST_READ_EN
    localparam bit fast_read = 1'b1;
`else
    localparam bit fast_read = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
    state_t state_q, state_d;
    logic [SRAM_AW-2:0] addr_q;
    logic [3:0]  be_q, cnt_q;
    logic [31:0] wdata_q, rdata_q;
    logic        wr_q, hi_q;
    logic        req, more, last, active;
    logic [1:0]  be_h;
    logic        unused_addr;
    assign unused_addr = ^{address[31:SRAM_AW+1], address[1:0]};
    assign req  = chipselect & (read | write);
    assign more = ~hi_q & |be_q[3:2];
    assign last = cnt_q == 4'(WAIT_CYCLES);
    assign waitrequest = req & (state_q != DONE);
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !req ? IDLE : (byteenable == 4'b0 ? DONE : SETUP);
            SETUP:   state_d = STROBE;
            STROBE:  state_d = !last ? STROBE : (fast_read && !wr_q) ? (more ? SETUP : DONE) : HOLD;
            HOLD:    state_d = more ? SETUP : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            hi_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                addr_q  <= address[SRAM_AW:2];
                be_q    <= byteenable;
                wdata_q <= writedata;
                wr_q    <= write;
                hi_q    <= ~|byteenable[1:0];
                if (!write) rdata_q <= '0;
            end
            if (state_q != IDLE && state_d == SETUP) hi_q <= 1'b1;
            if (state_q == SETUP) cnt_q <= '0;
            if (state_q == STROBE) cnt_q <= cnt_q + 4'd1;
            // only enabled lanes are captured, the rest stay zero from the accept
            if (state_q == STROBE && last && !wr_q) begin
                if (hi_q) rdata_q[31:16] <= sram_dq_in & {{8{be_q[3]}}, {8{be_q[2]}}};
                else      rdata_q[15:0]  <= sram_dq_in & {{8{be_q[1]}}, {8{be_q[0]}}};
            end
        end
    end
    always_comb begin
        active      = state_q == SETUP || state_q == STROBE || state_q == HOLD;
        be_h        = hi_q ? be_q[3:2] : be_q[1:0];
        sram_ce_n   = ~active;
        sram_lb_n   = ~(active & be_h[0]);
        sram_ub_n   = ~(active & be_h[1]);
        sram_oe_n   = ~(state_q == STROBE && !wr_q);
        sram_we_n   = ~(state_q == STROBE && wr_q);
        sram_dq_oe  = active & wr_q;
        sram_dq_out = hi_q ? wdata_q[31:16] : wdata_q[15:0];
        sram_addr   = {addr_q, hi_q};
        readdata    = rdata_q;
    end
endmodule

// File: tb/tb_sram_bus_slave.sv
// tb_sram_bus_slave: scoreboard bench for sram_bus_slave with a behavioural SRAM model.
module tb_sram_bus_slave;
    localparam int W = 2;
`ifdef SRAM_FAST_READ_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [31:0] address = '0, writedata = '0, readdata;
    logic [3:0]  byteenable = '0;
    logic        waitrequest;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_in, sram_dq_out;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    sram_bus_slave #(.SRAM_AW(20), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .waitrequest(waitrequest), .sram_addr(sram_addr),
        .sram_dq_in(sram_dq_in), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [31:0] rd; } exp_t;
    exp_t sb[$];
    int checks = 0, passed = 0;
    logic [15:0] mem [0:255];
    int n_we, n_oe, n_ce;
    logic [19:0] we_addr, oe_addr;
    logic we_lb, we_ub;
    logic [15:0] we_dq;

    assign sram_dq_in = !sram_oe_n ? mem[sram_addr[7:0]] : 16'h0;

    always @(negedge clk) if (!reset) begin
        if (!sram_ce_n) n_ce++;
        if (!sram_oe_n) begin n_oe++; oe_addr = sram_addr; end
        if (!sram_we_n) begin
            n_we++; we_addr = sram_addr; we_lb = sram_lb_n; we_ub = sram_ub_n; we_dq = sram_dq_out;
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  = sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] = sram_dq_out[15:8];
        end
    end

    // starts and ends just after a rising edge; cycle 0 is the cycle the request is presented
    task automatic access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output int cyc, output logic [31:0] rd);
        n_we = 0; n_oe = 0; n_ce = 0;
        chipselect = 1'b1; read = !wr; write = wr; address = addr; byteenable = be; writedata = wd;
        cyc = 0;
        @(negedge clk);
        while (waitrequest && cyc < 100) begin @(negedge clk); cyc++; end
        rd = readdata;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (waitrequest !== 1'b0) $display("FAIL reset_waitrequest: got %b expected 0", waitrequest); else passed++;
        checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111)
            $display("FAIL reset_strobes: got %b expected 11111", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}); else passed++;
        checks++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_dq_oe: got %b expected 0", sram_dq_oe); else passed++;
        checks++; if (sram_addr !== 20'h0) $display("FAIL reset_addr: got %h expected 0", sram_addr); else passed++;
        checks++; if (sram_dq_out !== 16'h0) $display("FAIL reset_dq_out: got %h expected 0", sram_dq_out); else passed++;
        checks++; if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected 0", readdata); else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_word_read();
        int c; logic [31:0] r; exp_t e;
        mem[8] = 16'hBEEF; mem[9] = 16'hDEAD;
        e.cyc = FAST ? 9 : 11; e.rd = 32'hDEADBEEF; sb.push_back(e);
        access(1'b0, 32'h10, 4'b1111, 32'h0, c, r);
        e = sb.pop_front();
        checks++; if (c !== e.cyc) $display("FAIL word_read_latency: got %0d expected %0d", c, e.cyc); else passed++;
        checks++; if (r !== e.rd) $display("FAIL word_read_data: got %h expected %h", r, e.rd); else passed++;
        checks++; if (n_oe !== 2 * (W + 1)) $display("FAIL word_read_oe_cycles: got %0d expected %0d", n_oe, 2 * (W + 1)); else passed++;
    endtask

    task automatic test_byte_write();
        int c; logic [31:0] r; exp_t e;
        mem[3] = 16'h1111;
        e.cyc = W + 4; e.rd = 32'h0; sb.push_back(e);
        access(1'b1, 32'h4, 4'b0100, 32'h00A50000, c, r);
        e = sb.pop_front();
        checks++; if (c !== e.cyc) $display("FAIL byte_write_latency: got %0d expected %0d", c, e.cyc); else passed++;
        checks++; if (n_we !== W + 1) $display("FAIL byte_write_we_cycles: got %0d expected %0d", n_we, W + 1); else passed++;
        checks++; if (we_addr !== 20'd3) $display("FAIL byte_write_addr: got %0d expected 3", we_addr); else passed++;
        checks++; if ({we_lb, we_ub} !== 2'b01) $display("FAIL byte_write_lanes: got lb_n=%b ub_n=%b expected lb_n=0 ub_n=1", we_lb, we_ub); else passed++;
        checks++; if (we_dq[7:0] !== 8'hA5) $display("FAIL byte_write_dq: got %h expected a5", we_dq[7:0]); else passed++;
        checks++; if (mem[3] !== 16'h11A5) $display("FAIL byte_write_mem: got %h expected 11a5", mem[3]); else passed++;
    endtask

    task automatic test_half_read();
        int c; logic [31:0] r; exp_t e;
        mem[16] = 16'hFFFF; mem[17] = 16'h1234;
        e.cyc = FAST ? W + 3 : W + 4; e.rd = 32'h12340000; sb.push_back(e);
        access(1'b0, 32'h20, 4'b1100, 32'h0, c, r);
        e = sb.pop_front();
        checks++; if (c !== e.cyc) $display("FAIL half_read_latency: got %0d expected %0d", c, e.cyc); else passed++;
        checks++; if (r !== e.rd) $display("FAIL half_read_data: got %h expected %h", r, e.rd); else passed++;
        checks++; if (oe_addr !== 20'd17) $display("FAIL half_read_addr: got %0d expected 17", oe_addr); else passed++;
        checks++; if (n_ce !== (FAST ? W + 2 : W + 3)) $display("FAIL half_read_ce_cycles: got %0d expected %0d", n_ce, FAST ? W + 2 : W + 3); else passed++;
    endtask

    task automatic test_be_zero();
        int c; logic [31:0] r; exp_t e;
        e.cyc = 1; e.rd = 32'h0; sb.push_back(e);
        access(1'b0, 32'h10, 4'b0000, 32'h0, c, r);
        e = sb.pop_front();
        checks++; if (c !== e.cyc) $display("FAIL be_zero_latency: got %0d expected %0d", c, e.cyc); else passed++;
        checks++; if (r !== e.rd) $display("FAIL be_zero_data: got %h expected %h", r, e.rd); else passed++;
        checks++; if (n_ce !== 0) $display("FAIL be_zero_activity: got %0d expected 0", n_ce); else passed++;
    endtask

    task automatic test_back_to_back();
        int c; logic [31:0] r; exp_t e;
        e.cyc = 2 * W + 7; e.rd = 32'h0; sb.push_back(e);
        access(1'b1, 32'h40, 4'b1111, 32'hCAFEF00D, c, r);
        e = sb.pop_front();
        checks++; if (c !== e.cyc) $display("FAIL b2b_write_latency: got %0d expected %0d", c, e.cyc); else passed++;
        checks++; if (n_we !== 2 * (W + 1)) $display("FAIL b2b_write_we_cycles: got %0d expected %0d", n_we, 2 * (W + 1)); else passed++;
        e.cyc = FAST ? 2 * W + 5 : 2 * W + 7; e.rd = 32'hCAFEF00D; sb.push_back(e);
        access(1'b0, 32'h40, 4'b1111, 32'h0, c, r);
        e = sb.pop_front();
        checks++; if (c !== e.cyc) $display("FAIL b2b_read_latency: got %0d expected %0d", c, e.cyc); else passed++;
        checks++; if (r !== e.rd) $display("FAIL b2b_read_data: got %h expected %h", r, e.rd); else passed++;
        e.cyc = FAST ? 2 * W + 5 : 2 * W + 7; e.rd = 32'h00FE000D; sb.push_back(e);
        access(1'b0, 32'h40, 4'b0101, 32'h0, c, r);
        e = sb.pop_front();
        checks++; if (c !== e.cyc) $display("FAIL lane_read_latency: got %0d expected %0d", c, e.cyc); else passed++;
        checks++; if (r !== e.rd) $display("FAIL lane_read_data: got %h expected %h", r, e.rd); else passed++;
    endtask

    task automatic test_reset_mid();
        int c; logic [31:0] r; exp_t e;
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = 32'h80; byteenable = 4'hF; writedata = 32'h55AA55AA;
        c = 0;
        @(negedge clk);
        while (sram_we_n && c < 50) begin @(negedge clk); c++; end
        checks++; if (sram_we_n !== 1'b0) $display("FAIL reset_mid_strobe_seen: got we_n=%b expected 0", sram_we_n); else passed++;
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({sram_we_n, sram_ce_n} !== 2'b11) $display("FAIL reset_mid_strobes: got we_n=%b ce_n=%b expected 1 1", sram_we_n, sram_ce_n); else passed++;
        checks++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_mid_dq_oe: got %b expected 0", sram_dq_oe); else passed++;
        checks++; if (waitrequest !== 1'b1) $display("FAIL reset_mid_waitrequest: got %b expected 1", waitrequest); else passed++;
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        @(posedge clk); #1;
        e.cyc = FAST ? 9 : 11; e.rd = 32'hDEADBEEF; sb.push_back(e);
        access(1'b0, 32'h10, 4'b1111, 32'h0, c, r);
        e = sb.pop_front();
        checks++; if (c !== e.cyc) $display("FAIL post_reset_read_latency: got %0d expected %0d", c, e.cyc); else passed++;
        checks++; if (r !== e.rd) $display("FAIL post_reset_read_data: got %h expected %h", r, e.rd); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        test_reset();
        test_word_read();
        test_byte_write();
        test_half_read();
        test_be_zero();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
